serial_adder_n: RTL and testbench



---
 rtl/serial_adder_n.sv | 108 ++++++++++
 tb/tb_serial_adder_n.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor built around one full-adder cell and one carry
// flip-flop. It processes WIDTH bits LSB-first, one bit per clock.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - operation request, sampled only while idle
//   a, b     - operands, captured on an accepted start
//   cin      - carry-in (borrow-in when sub=1), captured on an accepted start
//   sub      - 0: a+b+cin, 1: a-b-cin, captured on an accepted start
//   busy     - high while bits are being processed (exactly WIDTH cycles)
//   done     - one-cycle pulse when sum/cout/overflow are updated
//   sum      - result register, changes only at completion
//   cout     - carry-out; for subtraction 1 means no borrow
//   overflow - two's-complement signed overflow of the last result
module serial_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_next;

  always_comb begin
    w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_last = (r_cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts the LSB-first stream
    // sits in natural bit order. Written as a shift of the concatenation so
    // it also holds for WIDTH=1.
    w_psum_next = WIDTH'({w_s, r_psum} >> 1);
    busy        = (r_state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_psum   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            // Subtraction as a + ~b + 1; a borrow-in removes the +1.
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_psum  <= w_psum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // r_carry still holds the carry into the MSB on the last bit.
            sum      <= w_psum_next;
            cout     <= w_c;
            overflow <= r_carry ^ w_c;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       st8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ov8;
  logic [7:0] sum8;

  logic       st4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ov4;
  logic [3:0] sum4;

  serial_adder_n #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  serial_adder_n #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  // Arithmetic reference: unsigned sum for sum/cout, signed range test for overflow.
  function automatic res_t calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic ci, input logic sb);
    res_t        r;
    logic [63:0] mask;
    logic [64:0] full;
    longint      sa, sbv, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    full = {1'b0, a & mask} + {1'b0, (sb ? ~b : b) & mask} + 65'(ci ^ sb);
    r.s  = full[63:0] & mask;
    r.co = full[w];
    lim  = longint'(1) << (w - 1);
    sa   = longint'(a & mask) - (a[w-1] ? (longint'(1) << w) : 0);
    sbv  = longint'(b & mask) - (b[w-1] ? (longint'(1) << w) : 0);
    sr   = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
    r.ov = (sr > lim - 1) || (sr < -lim);
    return r;
  endfunction

  res_t c8, c4;
  always_comb c8 = calc(8, {56'b0, a8}, {56'b0, b8}, cin8, sub8);
  always_comb c4 = calc(4, {60'b0, a4}, {60'b0, b4}, cin4, sub4);

  // Transaction-level model: an accepted start yields its result WIDTH edges later.
  res_t m8, p8, m4, p4;
  logic m8_busy, m8_done, m4_busy, m4_done;
  int   m8_left, m4_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '0; p8 <= '0; m8_busy <= 1'b0; m8_done <= 1'b0; m8_left <= 0;
    end else begin
      m8_done <= 1'b0;
      if (m8_busy) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin
          m8_busy <= 1'b0; m8_done <= 1'b1; m8 <= p8;
        end
      end else if (st8) begin
        p8 <= c8; m8_busy <= 1'b1; m8_left <= 8;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '0; p4 <= '0; m4_busy <= 1'b0; m4_done <= 1'b0; m4_left <= 0;
    end else begin
      m4_done <= 1'b0;
      if (m4_busy) begin
        m4_left <= m4_left - 1;
        if (m4_left == 1) begin
          m4_busy <= 1'b0; m4_done <= 1'b1; m4 <= p4;
        end
      end else if (st4) begin
        p4 <= c4; m4_busy <= 1'b1; m4_left <= 4;
      end
    end
  end

  always @(negedge clk) begin
    check("busy8", busy8, m8_busy);
    check("done8", done8, m8_done);
    check("sum8", sum8, m8.s[7:0]);
    check("cout8", cout8, m8.co);
    check("ovf8", ov8, m8.ov);
    check("busy4", busy4, m4_busy);
    check("done4", done4, m4_done);
    check("sum4", sum4, m4.s[3:0]);
    check("cout4", cout4, m4.co);
    check("ovf4", ov4, m4.ov);
  end

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo, input bit inject);
    int n, nb;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    nb = busy8 ? 1 : 0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
      if (inject && n == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; st8 = 1'b1;
      end else begin
        st8 = 1'b0;
      end
    end
    check("latency8", n, 8);
    check("busy_len8", nb, 8);
    check("lit_sum8", sum8, es);
    check("lit_cout8", cout8, ec);
    check("lit_ovf8", ov8, eo);
    check("model_sum8", m8.s[7:0], es);
    check("model_cout8", m8.co, ec);
    check("model_ovf8", m8.ov, eo);
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    while ((busy8 || done8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle8_timeout", n < 20, 1);
  endtask

  initial begin
    int last, ndone, n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_ovf8", ov8, 0);

    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    do_op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    // Start (and operand changes) mid-run must be ignored.
    do_op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

    // Start held high: a new operation every 9 cycles.
    @(negedge clk);
    st8 = 1'b1;
    last = -1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (last >= 0) check("held_period8", i - last, 9);
        last = i;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    end
    st8 = 1'b0;
    check("held_done_count8", ndone >= 4, 1);
    wait_idle8();

    // Asynchronous reset in the 4th cycle of a run.
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy8", busy8, 0);
    check("arst_done8", done8, 0);
    check("arst_sum8", sum8, 0);
    check("arst_cout8", cout8, 0);
    check("arst_ovf8", ov8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_op8(8'h77, 8'h11, 1'b0, 1'b0, 8'h88, 1'b0, 1'b1, 1'b0);

    // Random traffic with starts arriving at arbitrary times.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      st8 = ($urandom_range(0, 3) == 0);
    end
    st8 = 1'b0;
    wait_idle8();

    // Exhaustive WIDTH=4 sweep.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            @(negedge clk);
            a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(is); st4 = 1'b1;
            @(negedge clk);
            st4 = 1'b0;
            n = 0;
            while (!done4 && n < 10) begin
              @(negedge clk);
              n++;
            end
            check("latency4", n, 4);
          end
    // Last sweep point: 15 - 15 - 1 = -1, borrow out, no overflow.
    check("lit_sum4", sum4, 4'hF);
    check("lit_cout4", cout4, 0);
    check("lit_ovf4", ov4, 0);
    check("model_sum4", m4.s[3:0], 4'hF);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
